// File: rtl/dcache_mshr.sv
// dcache_mshr: miss status holding queue behind the dcache load pipe s2 stage.
// Misses are queued in order and fetched one line at a time over the refill bus.
// Each returned line is written to the tag/data arrays, and then the load that
// missed is woken up by its robid.
//
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   flush                   pipeline flush; drops queued misses
//   mshr_allocate_*         miss request from s2 (valid/ready, paddr, robid)
//   bus_req_*               refill read request (valid/ready, line-aligned paddr)
//   bus_resp_*              single-beat line response (valid, data)
//   refill_*                array write request (valid/ready, paddr, data)
//   wakeup_*                one-cycle replay pulse carrying the robid
//   mshr_full               every entry is occupied
module dcache_mshr #(
    parameter int unsigned MSHR_NUM    = 4,
    parameter int unsigned LINE_OFFSET = 6,
    parameter int unsigned LINE_WIDTH  = 512,
    parameter int unsigned PADDR_WIDTH = 32,
    parameter int unsigned ROBID_WIDTH = 7
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   mshr_allocate_valid,
    output logic                   mshr_allocate_ready,
    input  logic [PADDR_WIDTH-1:0] mshr_allocate_paddr,
    input  logic [ROBID_WIDTH-1:0] mshr_allocate_robid,
    output logic                   bus_req_valid,
    input  logic                   bus_req_ready,
    output logic [PADDR_WIDTH-1:0] bus_req_paddr,
    input  logic                   bus_resp_valid,
    input  logic [LINE_WIDTH-1:0]  bus_resp_data,
    output logic                   refill_valid,
    input  logic                   refill_ready,
    output logic [PADDR_WIDTH-1:0] refill_paddr,
    output logic [LINE_WIDTH-1:0]  refill_data,
    output logic                   wakeup_valid,
    output logic [ROBID_WIDTH-1:0] wakeup_robid,
    output logic                   mshr_full
);

    localparam int unsigned PTR_W = $clog2(MSHR_NUM);
    localparam int unsigned TAG_W = PADDR_WIDTH - LINE_OFFSET;
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_REFILL,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic                   ent_valid  [MSHR_NUM];
    logic [TAG_W-1:0]       ent_tag    [MSHR_NUM];
    logic [ROBID_WIDTH-1:0] ent_robid  [MSHR_NUM];
    logic                   ent_killed [MSHR_NUM];

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0]         head, tail;
    logic [PTR_W-1:0]       head_idx, tail_idx;
    logic                   full, line_hit, alloc_fire, retire, keep_head;
    logic [TAG_W-1:0]       alloc_tag;
    logic [PADDR_WIDTH-1:0] head_line;
    logic                   unused_low_bits;

    assign head_idx        = head[PTR_W-1:0];
    assign tail_idx        = tail[PTR_W-1:0];
    assign full            = (head_idx == tail_idx) && (head[PTR_W] != tail[PTR_W]);
    assign alloc_tag       = mshr_allocate_paddr[PADDR_WIDTH-1:LINE_OFFSET];
    assign head_line       = {ent_tag[head_idx], {LINE_OFFSET{1'b0}}};
    assign unused_low_bits = ^mshr_allocate_paddr[LINE_OFFSET-1:0];

    // Same-line misses stall rather than merge; the retiring head still counts.
    always_comb begin
        line_hit = 1'b0;
        for (int unsigned i = 0; i < MSHR_NUM; i++) begin
            if (ent_valid[i] && (ent_tag[i] == alloc_tag)) begin
                line_hit = 1'b1;
            end
        end
    end

    assign mshr_allocate_ready = !full && !flush && !line_hit;
    assign alloc_fire          = mshr_allocate_valid && mshr_allocate_ready;
    assign retire              = (state == S_RESP);
    assign mshr_full           = full;

    // A head whose request the bus has taken (including in the flush cycle
    // itself) must finish its refill, so it survives a flush as a killed entry.
    assign keep_head = (state == S_WAIT) || (state == S_REFILL) ||
                       ((state == S_REQ) && bus_req_ready);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < MSHR_NUM; i++) begin
                ent_valid[i]  <= 1'b0;
                ent_tag[i]    <= '0;
                ent_robid[i]  <= '0;
                ent_killed[i] <= 1'b0;
            end
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < MSHR_NUM; i++) begin
                if (!(keep_head && (PTR_W'(i) == head_idx))) begin
                    ent_valid[i] <= 1'b0;
                end
            end
            if (keep_head) begin
                ent_killed[head_idx] <= 1'b1;
            end
            // A head retiring during the flush still advances; the tail then
            // lands on the new head so the queue ends up empty.
            if (retire) begin
                head <= head + PTR_ONE;
            end
            tail <= (keep_head || retire) ? head + PTR_ONE : head;
        end else begin
            if (alloc_fire) begin
                ent_valid[tail_idx]  <= 1'b1;
                ent_tag[tail_idx]    <= alloc_tag;
                ent_robid[tail_idx]  <= mshr_allocate_robid;
                ent_killed[tail_idx] <= 1'b0;
                tail                 <= tail + PTR_ONE;
            end
            if (retire) begin
                ent_valid[head_idx] <= 1'b0;
                head                <= head + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            refill_data <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_WAIT) && bus_resp_valid) begin
                refill_data <= bus_resp_data;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus_req_valid = 1'b0;
        bus_req_paddr = '0;
        refill_valid  = 1'b0;
        refill_paddr  = '0;
        wakeup_valid  = 1'b0;
        wakeup_robid  = '0;
        case (state)
            S_IDLE: begin
                if (ent_valid[head_idx] && !flush) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                bus_req_valid = 1'b1;
                bus_req_paddr = head_line;
                if (bus_req_ready) begin
                    state_nxt = S_WAIT;
                end else if (flush) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus_resp_valid) begin
                    state_nxt = S_REFILL;
                end
            end
            S_REFILL: begin
                refill_valid = 1'b1;
                refill_paddr = head_line;
                if (refill_ready) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (!ent_killed[head_idx]) begin
                    wakeup_valid = 1'b1;
                    wakeup_robid = ent_robid[head_idx];
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_mshr.sv
// tb_dcache_mshr: directed bench for dcache_mshr.
// Inputs change 1ns after the rising edge; outputs are compared 2-3ns after it.
// Covers single miss, fill/full/wrap, same-line stall, flush in WAIT,
// refill backpressure and reset during REFILL.
`define CHK(name, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, name, (obs), (exp)); \
    end \
  end

module tb_dcache_mshr;

  localparam int unsigned LW = 512;

  logic           clock;
  logic           reset_n;
  logic           flush;
  logic           mshr_allocate_valid;
  logic           mshr_allocate_ready;
  logic [31:0]    mshr_allocate_paddr;
  logic [6:0]     mshr_allocate_robid;
  logic           bus_req_valid;
  logic           bus_req_ready;
  logic [31:0]    bus_req_paddr;
  logic           bus_resp_valid;
  logic [LW-1:0]  bus_resp_data;
  logic           refill_valid;
  logic           refill_ready;
  logic [31:0]    refill_paddr;
  logic [LW-1:0]  refill_data;
  logic           wakeup_valid;
  logic [6:0]     wakeup_robid;
  logic           mshr_full;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  dcache_mshr #(
    .MSHR_NUM    (4),
    .LINE_OFFSET (6),
    .LINE_WIDTH  (LW),
    .PADDR_WIDTH (32),
    .ROBID_WIDTH (7)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .flush               (flush),
    .mshr_allocate_valid (mshr_allocate_valid),
    .mshr_allocate_ready (mshr_allocate_ready),
    .mshr_allocate_paddr (mshr_allocate_paddr),
    .mshr_allocate_robid (mshr_allocate_robid),
    .bus_req_valid       (bus_req_valid),
    .bus_req_ready       (bus_req_ready),
    .bus_req_paddr       (bus_req_paddr),
    .bus_resp_valid      (bus_resp_valid),
    .bus_resp_data       (bus_resp_data),
    .refill_valid        (refill_valid),
    .refill_ready        (refill_ready),
    .refill_paddr        (refill_paddr),
    .refill_data         (refill_data),
    .wakeup_valid        (wakeup_valid),
    .wakeup_robid        (wakeup_robid),
    .mshr_full           (mshr_full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_reset_state();
    checks++;
    if (bus_req_valid !== 1'b0 || refill_valid !== 1'b0 || wakeup_valid !== 1'b0 ||
        mshr_full !== 1'b0 || bus_req_paddr !== 32'h0 || refill_paddr !== 32'h0 ||
        refill_data !== {LW{1'b0}} || wakeup_robid !== 7'h0) begin
      errors++;
      $error("FAIL %s/reset_state outputs not all zero: req=%0b refill=%0b wakeup=%0b full=%0b",
             phase, bus_req_valid, refill_valid, wakeup_valid, mshr_full);
    end
  endtask

  task automatic alloc(input logic [31:0] pa, input logic [6:0] rob, input logic exp_ready);
    mshr_allocate_valid = 1'b1;
    mshr_allocate_paddr = pa;
    mshr_allocate_robid = rob;
    settle();
    `CHK("alloc_ready", mshr_allocate_ready, exp_ready)
    step();
    mshr_allocate_valid = 1'b0;
    settle();
  endtask

  // Waits (bounded) for the request, accepts it, returns the line, and
  // leaves the bench in the first REFILL cycle.
  task automatic get_to_refill(input logic [31:0] exp_pa, input logic [LW-1:0] data);
    int unsigned n;
    n = 0;
    bus_req_ready = 1'b1;
    while (bus_req_valid !== 1'b1 && n < 20) begin
      step();
      settle();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $error("FAIL %s/req_wait timed out after %0d cycles waiting for bus_req_valid", phase, n);
    end
    `CHK("req_valid", bus_req_valid, 1'b1)
    `CHK("req_paddr", bus_req_paddr, exp_pa)
    step();
    bus_req_ready = 1'b0;
    settle();
    `CHK("req_drop", bus_req_valid, 1'b0)
    bus_resp_valid = 1'b1;
    bus_resp_data  = data;
    step();
    bus_resp_valid = 1'b0;
    settle();
    `CHK("refill_valid", refill_valid, 1'b1)
    `CHK("refill_paddr", refill_paddr, exp_pa)
    `CHK("refill_data", refill_data, data)
  endtask

  task automatic serve(input logic [31:0] exp_pa, input logic [6:0] exp_rob, input logic [LW-1:0] data);
    get_to_refill(exp_pa, data);
    refill_ready = 1'b1;
    step();
    settle();
    `CHK("wakeup_valid", wakeup_valid, 1'b1)
    `CHK("wakeup_robid", wakeup_robid, exp_rob)
    step();
    settle();
    `CHK("wakeup_pulse", wakeup_valid, 1'b0)
  endtask

  initial begin
    logic [LW-1:0] d;

    reset_n             = 1'b0;
    flush               = 1'b0;
    mshr_allocate_valid = 1'b0;
    mshr_allocate_paddr = '0;
    mshr_allocate_robid = '0;
    bus_req_ready       = 1'b0;
    bus_resp_valid      = 1'b0;
    bus_resp_data       = '0;
    refill_ready        = 1'b0;

    step();
    step();
    settle();
    phase = "reset";
    check_reset_state();
    `CHK("bus_req_valid", bus_req_valid, 1'b0)
    `CHK("refill_valid", refill_valid, 1'b0)
    `CHK("wakeup_valid", wakeup_valid, 1'b0)
    `CHK("mshr_full", mshr_full, 1'b0)
    `CHK("bus_req_paddr", bus_req_paddr, 32'h0)
    `CHK("refill_data", refill_data, {LW{1'b0}})
    reset_n      = 1'b1;
    refill_ready = 1'b1;

    // Single miss with exact cycle timing.
    phase = "single";
    d = {16{32'h1111_0001}};
    mshr_allocate_valid = 1'b1;
    mshr_allocate_paddr = 32'h8000_1234;
    mshr_allocate_robid = 7'd5;
    bus_req_ready       = 1'b1;
    settle();
    `CHK("alloc_ready", mshr_allocate_ready, 1'b1)
    step();
    mshr_allocate_valid = 1'b0;
    settle();
    `CHK("req_lat1", bus_req_valid, 1'b0)
    step();
    settle();
    `CHK("req_lat2", bus_req_valid, 1'b1)
    `CHK("req_paddr", bus_req_paddr, 32'h8000_1200)
    step();
    bus_req_ready = 1'b0;
    settle();
    `CHK("req_drop", bus_req_valid, 1'b0)
    step();
    step();
    bus_resp_valid = 1'b1;
    bus_resp_data  = d;
    step();
    bus_resp_valid = 1'b0;
    settle();
    `CHK("refill_valid", refill_valid, 1'b1)
    `CHK("refill_paddr", refill_paddr, 32'h8000_1200)
    `CHK("refill_data", refill_data, d)
    `CHK("early_wakeup", wakeup_valid, 1'b0)
    step();
    settle();
    `CHK("wakeup_valid", wakeup_valid, 1'b1)
    `CHK("wakeup_robid", wakeup_robid, 7'd5)
    step();
    settle();
    `CHK("wakeup_pulse", wakeup_valid, 1'b0)

    // Fill all four entries while the bus stalls, then drain in order.
    phase = "fill";
    for (int k = 0; k < 4; k++) begin
      alloc(32'h0000_2000 + 32'(k) * 32'h100 + 32'h3C, 7'(10 + k), 1'b1);
    end
    `CHK("full", mshr_full, 1'b1)
    alloc(32'h0000_2500, 7'd14, 1'b0);
    for (int k = 0; k < 4; k++) begin
      serve(32'h0000_2000 + 32'(k) * 32'h100, 7'(10 + k), {16{32'(32'h2200_0000 + k)}});
    end
    `CHK("drained", mshr_full, 1'b0)

    phase = "wrap";
    for (int k = 0; k < 4; k++) begin
      alloc(32'h0003_0011 + 32'(k) * 32'h40, 7'(60 + k), 1'b1);
    end
    `CHK("full_a", mshr_full, 1'b1)
    for (int k = 0; k < 2; k++) begin
      serve(32'h0003_0000 + 32'(k) * 32'h40, 7'(60 + k), {16{32'(32'h3300_0000 + k)}});
    end
    for (int k = 4; k < 6; k++) begin
      alloc(32'h0003_0011 + 32'(k) * 32'h40, 7'(60 + k), 1'b1);
    end
    `CHK("full_b", mshr_full, 1'b1)
    for (int k = 2; k < 6; k++) begin
      serve(32'h0003_0000 + 32'(k) * 32'h40, 7'(60 + k), {16{32'(32'h3300_0000 + k)}});
    end

    // A second miss to an in-flight line waits for the first to retire.
    phase = "same_line";
    alloc(32'h0000_1000, 7'd20, 1'b1);
    mshr_allocate_valid = 1'b1;
    mshr_allocate_paddr = 32'h0000_1020;
    mshr_allocate_robid = 7'd21;
    settle();
    `CHK("stall_ready", mshr_allocate_ready, 1'b0)
    serve(32'h0000_1000, 7'd20, {16{32'h4444_0001}});
    `CHK("after_ready", mshr_allocate_ready, 1'b1)
    step();
    mshr_allocate_valid = 1'b0;
    settle();
    serve(32'h0000_1000, 7'd21, {16{32'h4444_0002}});

    // Flush while the head is in WAIT.
    phase = "flush";
    for (int k = 0; k < 3; k++) begin
      alloc(32'h4000_0000 + 32'(k) * 32'h100, 7'(30 + k), 1'b1);
    end
    bus_req_ready = 1'b1;
    settle();
    `CHK("req_valid", bus_req_valid, 1'b1)
    `CHK("req_paddr", bus_req_paddr, 32'h4000_0000)
    step();
    bus_req_ready = 1'b0;
    flush         = 1'b1;
    settle();
    `CHK("flush_blocks_alloc", mshr_allocate_ready, 1'b0)
    step();
    flush = 1'b0;
    settle();
    `CHK("full_after_flush", mshr_full, 1'b0)
    // Killed head still holds its slot, so three allocations fill the queue.
    for (int k = 0; k < 3; k++) begin
      alloc(32'h0000_6000 + 32'(k) * 32'h100, 7'(70 + k), 1'b1);
    end
    `CHK("full_reuse", mshr_full, 1'b1)
    d = {16{32'h5555_0001}};
    bus_resp_valid = 1'b1;
    bus_resp_data  = d;
    step();
    bus_resp_valid = 1'b0;
    settle();
    `CHK("killed_refill_valid", refill_valid, 1'b1)
    `CHK("killed_refill_paddr", refill_paddr, 32'h4000_0000)
    `CHK("killed_refill_data", refill_data, d)
    step();
    settle();
    `CHK("killed_no_wakeup", wakeup_valid, 1'b0)
    for (int k = 0; k < 3; k++) begin
      serve(32'h0000_6000 + 32'(k) * 32'h100, 7'(70 + k), {16{32'(32'h6600_0000 + k)}});
    end

    // Refill port withheld for four cycles.
    phase = "backpressure";
    d = {16{32'h7777_0005}};
    refill_ready = 1'b0;
    alloc(32'h7000_0A9F, 7'd40, 1'b1);
    get_to_refill(32'h7000_0A80, d);
    for (int k = 0; k < 4; k++) begin
      step();
      settle();
      `CHK("held_valid", refill_valid, 1'b1)
      `CHK("held_paddr", refill_paddr, 32'h7000_0A80)
      `CHK("held_data", refill_data, d)
      `CHK("held_no_wakeup", wakeup_valid, 1'b0)
    end
    refill_ready = 1'b1;
    step();
    settle();
    `CHK("wakeup_valid", wakeup_valid, 1'b1)
    `CHK("wakeup_robid", wakeup_robid, 7'd40)
    step();
    settle();
    `CHK("wakeup_pulse", wakeup_valid, 1'b0)

    // Reset while in REFILL.
    phase = "reset_refill";
    refill_ready = 1'b0;
    alloc(32'h9000_0000, 7'd50, 1'b1);
    get_to_refill(32'h9000_0000, {16{32'h9999_0001}});
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    settle();
    check_reset_state();
    `CHK("bus_req_valid", bus_req_valid, 1'b0)
    `CHK("refill_valid", refill_valid, 1'b0)
    `CHK("wakeup_valid", wakeup_valid, 1'b0)
    `CHK("mshr_full", mshr_full, 1'b0)
    `CHK("refill_paddr", refill_paddr, 32'h0)
    `CHK("refill_data", refill_data, {LW{1'b0}})
    `CHK("bus_req_paddr", bus_req_paddr, 32'h0)
    bus_resp_valid = 1'b1;
    bus_resp_data  = {16{32'hDEAD_BEEF}};
    step();
    bus_resp_valid = 1'b0;
    settle();
    `CHK("late_resp_ignored", refill_valid, 1'b0)
    `CHK("late_resp_data", refill_data, {LW{1'b0}})
    refill_ready = 1'b1;
    alloc(32'h9100_0040, 7'd51, 1'b1);
    serve(32'h9100_0040, 7'd51, {16{32'h9999_0002}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
